// File: rtl/fft_mag_reader_pkg.sv
// Shared types and sizes for the FFT magnitude reader.
package fft_pkg;
  localparam int N_POINTS   = 4096;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int HALF_W     = DATA_W / 2;
  localparam int FIFO_DEPTH = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   cnt_t;
  typedef logic [DATA_W-1:0] mag_t;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} reader_state_e;

  localparam cnt_t CNT_FULL = cnt_t'(N_POINTS);
  localparam cnt_t CNT_LAST = cnt_t'(N_POINTS - 1);
endpackage

// File: rtl/fft_mag_reader_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             full;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_pop = pop & ~empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Upstream credit accounting must keep a full FIFO from ever being written without a pop.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !do_pop));
endmodule

// File: rtl/fft_mag_reader.sv
// Sweeps the FFT result RAM after a rising fft_done and streams re^2+im^2 per bin.
// Define FFT_SHIFT_EN to emit bins in fftshift order (N/2 .. N-1, then 0 .. N/2-1).
module fft_mag_reader
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fft_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              busy,
  output logic              frame_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = 1 + ADDR_W + DATA_W;

  function automatic mag_t mag_sq(input cplx_t c);
    logic signed [DATA_W-1:0] re_w;
    logic signed [DATA_W-1:0] im_w;
    re_w = c.re;
    im_w = c.im;
    // Each square is < 2^31 and the sum peaks at exactly 2^31, so unsigned DATA_W never wraps.
    return mag_t'(re_w * re_w) + mag_t'(im_w * im_w);
  endfunction

  reader_state_e state, state_nx;
  logic          done_q;
  logic          start;
  cnt_t          rd_cnt;
  cnt_t          out_cnt;
  addr_t         base_addr;
  logic          credit_ok;
  logic          drain_done;
  logic          pop;

  logic          vld_p0;
  addr_t         idx_p0;
  logic          last_p0;
  logic          vld_p1;
  addr_t         idx_p1;
  logic          last_p1;
  mag_t          mag_p1;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [FW-1:0] fifo_dout;
  logic          f_last;
  addr_t         f_index;
  mag_t          f_data;

  assign start = fft_done & ~done_q;

`ifdef FFT_SHIFT_EN
  localparam addr_t HALF_ADDR = addr_t'(N_POINTS / 2);
  assign base_addr = rd_cnt[ADDR_W-1:0] ^ HALF_ADDR;
`else
  assign base_addr = rd_cnt[ADDR_W-1:0];
`endif

  assign credit_ok  = (int'(fifo_count) + int'(vld_p0) + int'(vld_p1)) < FIFO_DEPTH;
  assign pop        = m_valid & m_ready;
  // The final word leaving now with nothing behind it or still in flight ends the frame.
  assign drain_done = pop && (out_cnt == CNT_LAST) && (fifo_count == CW'(1)) && !vld_p0 && !vld_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      done_q  <= 1'b0;
      rd_cnt  <= '0;
      out_cnt <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= fft_done;
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
      if (state == IDLE && start) begin
        rd_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (rd_en) rd_cnt  <= rd_cnt + cnt_t'(1);
        if (pop)   out_cnt <= out_cnt + cnt_t'(1);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    rd_en      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (start) state_nx = READ;
      READ: begin
        busy = 1'b1;
        if (rd_cnt == CNT_FULL) state_nx = DRAIN;
        else if (credit_ok)     rd_en    = 1'b1;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_done) state_nx = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // p0: read issued, RAM word arrives on rd_data
  always_ff @(posedge clk) begin
    idx_p0  <= base_addr;
    last_p0 <= (rd_cnt == CNT_LAST);
  end

  // p1: magnitude squared registered, pushed into the FIFO next edge
  always_ff @(posedge clk) begin
    mag_p1  <= mag_sq(cplx_t'(rd_data));
    idx_p1  <= idx_p0;
    last_p1 <= last_p0;
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (vld_p1),
    .pop   (pop),
    .din   ({last_p1, idx_p1, mag_p1}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign {f_last, f_index, f_data} = fifo_dout;

  assign m_valid = ~fifo_empty;
  assign m_data  = m_valid ? f_data  : '0;
  assign m_index = m_valid ? f_index : '0;
  assign m_last  = m_valid & f_last;
  assign rd_addr = rd_en ? base_addr : '0;
endmodule

// File: tb/tb_fft_mag_reader.sv
// Bench for fft_mag_reader: RAM model, randomized backpressure, reference magnitudes.
module tb_fft_mag_reader;
  localparam int N     = 4096;
  localparam int DEPTH = 4;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fft_done = 1'b0;
  logic        m_ready = 1'b0;
  logic        rd_en, m_valid, m_last, busy, frame_done;
  logic [11:0] rd_addr, m_index;
  logic [31:0] rd_data, m_data;

  logic [31:0] mem [N];
  logic [31:0] got_by_bin [N];
  int          checks = 0;
  int          passed = 0;

  typedef struct {
    int                 bin;
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [31:0]        exp;
  } vec_t;
  vec_t tbl [7];

  fft_mag_reader dut (
    .clk        (clk),
    .reset      (reset),
    .fft_done   (fft_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_index    (m_index),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic longint exp_mag(input logic [31:0] w);
    longint re, im;
    re = longint'($signed(w[31:16]));
    im = longint'($signed(w[15:0]));
    return re * re + im * im;
  endfunction

  function automatic int exp_bin(input int k);
`ifdef FFT_SHIFT_EN
    return (k + N / 2) % N;
`else
    return k;
`endif
  endfunction

  task automatic run_frame(input string tag, input int pct, input int abort_at, input bit reedge);
    int   cyc, k, issued, first_v, last_cyc, fd_cyc, fd_pulses;
    int   bad_data, bad_idx, bad_last, stall_bad, credit_bad, extra, busy1;
    logic prev_stall, pl;
    logic [31:0] pd;
    logic [11:0] pi;
    cyc = 0; k = 0; issued = 0; first_v = -1; last_cyc = -1; fd_cyc = -1; fd_pulses = 0;
    bad_data = 0; bad_idx = 0; bad_last = 0; stall_bad = 0; credit_bad = 0; extra = 0; busy1 = 0;
    prev_stall = 1'b0; pd = '0; pi = '0; pl = 1'b0;
    @(negedge clk); fft_done = 1'b0;
    @(negedge clk); fft_done = 1'b1;
    while (cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = int'(busy);
      if (rd_en) begin
        if (issued - k >= DEPTH) credit_bad++;
        issued++;
      end
      if (prev_stall && !(m_valid && m_data == pd && m_index == pi && m_last == pl)) stall_bad++;
      if (m_valid && first_v < 0) first_v = cyc;
      if (frame_done) begin fd_pulses++; fd_cyc = cyc; end
      if (abort_at >= 0 && k == abort_at) break;
      if (reedge && cyc == 300) fft_done = 1'b0;
      if (reedge && cyc == 303) fft_done = 1'b1;
      m_ready = ($urandom_range(99) < pct);
      if (m_valid && m_ready) begin
        if (k >= N) extra++;
        else begin
          if (int'(m_index) != exp_bin(k)) bad_idx++;
          if (longint'(m_data) != exp_mag(mem[exp_bin(k)])) bad_data++;
          if (m_last != (k == N - 1)) bad_last++;
          got_by_bin[m_index] = m_data;
          if (k == N - 1) last_cyc = cyc;
          k++;
        end
      end
      prev_stall = m_valid && !m_ready;
      pd = m_data; pi = m_index; pl = m_last;
      if (k >= N && cyc >= last_cyc + 8) break;
    end

    check({tag, " credit never exceeded"}, credit_bad, 0);
    check({tag, " outputs stable while stalled"}, stall_bad, 0);
    check({tag, " first m_valid latency"}, first_v, 4);
    check({tag, " busy after start"}, busy1, 1);
    check({tag, " data errors"}, bad_data, 0);
    check({tag, " index errors"}, bad_idx, 0);
    if (abort_at >= 0) begin
      check({tag, " words before reset"}, k, abort_at);
      reset = 1'b0;
      #1;
      check({tag, " outputs cleared by reset"},
            longint'({rd_en, rd_addr, m_valid, m_data, m_index, m_last, busy, frame_done}), 0);
      fft_done = 1'b0;
      m_ready  = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, " held in reset"}, longint'({rd_en, m_valid, busy, frame_done}), 0);
      reset = 1'b1;
      @(negedge clk);
      return;
    end
    check({tag, " words emitted"}, k, N);
    check({tag, " words past the last"}, extra, 0);
    check({tag, " m_last errors"}, bad_last, 0);
    check({tag, " frame_done pulses"}, fd_pulses, 1);
    check({tag, " frame_done after last accept"}, fd_cyc - last_cyc, 1);
    check({tag, " busy at end"}, int'(busy), 0);
    if (pct == 100) check({tag, " back-to-back span"}, last_cyc - first_v, N - 1);
  endtask

  initial begin
    int idle_bad;
    tbl[0] = '{7,  16'h8000,     16'h8000,     32'h8000_0000};
    tbl[1] = '{8,  16'sd3,       -16'sd4,      32'd25};
    tbl[2] = '{9,  16'sd32767,   16'sd32767,   32'h7FFE_0002};
    tbl[3] = '{10, -16'sd1,      16'sd0,       32'd1};
    tbl[4] = '{11, 16'sd0,       16'sd0,       32'd0};
    tbl[5] = '{12, 16'h8000,     16'sd0,       32'h4000_0000};
    tbl[6] = '{13, 16'sd32767,   16'h8000,     32'h7FFF_0001};

    for (int i = 0; i < N; i++) mem[i] = {16'(i), 16'h0000};

    #2;
    check("reset state", longint'({rd_en, rd_addr, m_valid, m_data, m_index, m_last, busy, frame_done}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_frame("ramp", 100, -1, 1'b0);
    check("ramp bin 3", got_by_bin[3], 9);
    check("ramp bin 4095", got_by_bin[4095], 32'd16769025);
    check("ramp bin 2048", got_by_bin[2048], 32'd4194304);

    for (int t = 0; t < 7; t++) mem[tbl[t].bin] = {tbl[t].re, tbl[t].im};
    run_frame("corners", 30, -1, 1'b0);
    for (int t = 0; t < 7; t++)
      check($sformatf("corner bin %0d", tbl[t].bin), got_by_bin[tbl[t].bin], tbl[t].exp);

    for (int i = 0; i < N; i++) mem[i] = $urandom;
    run_frame("random", 60, -1, 1'b0);

    run_frame("abort", 50, 1000, 1'b0);

    run_frame("restart", 100, -1, 1'b1);

    idle_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_en || busy || m_valid) idle_bad++;
    end
    check("no restart while fft_done held", idle_bad, 0);
    fft_done = 1'b0;
    @(negedge clk);
    fft_done = 1'b1;
    @(negedge clk);
    check("new edge starts a frame", int'(busy), 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
